wave_sequencer: RTL and testbench

Sequences the CORDIC wave generator through a programmable table of tones. Each entry holds waveform, phase, amplitude and dwell. On run, the block loads each entry into the generator via its set_phase/set_amplitude strobes, enables it for a dwell of N output samples, then advances. It sits between the chip pins/config logic and wave_generator, replacing direct pin control of enable/waveform/strobes.

---
 rtl/wave_sequencer_if.sv | 20 ++
 rtl/wave_sequencer.sv | 171 +++++++++++++++++
 tb/tb_wave_sequencer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wave_sequencer_if.sv
// Generator-side bus between wave_sequencer and the CORDIC wave_generator.
// The sequencer drives the load strobes and enable and receives one valid pulse per output sample.
interface wave_sequencer_if;
  logic       gen_valid;
  logic       gen_enable;
  logic [1:0] gen_waveform;
  logic       gen_set_phase;
  logic       gen_set_amplitude;
  logic [7:0] gen_data;

  modport master (
    input  gen_valid,
    output gen_enable, gen_waveform, gen_set_phase, gen_set_amplitude, gen_data
  );

  modport slave (
    output gen_valid,
    input  gen_enable, gen_waveform, gen_set_phase, gen_set_amplitude, gen_data
  );
endinterface

// File: rtl/wave_sequencer.sv
// Steps wave_generator through a table of {phase, amplitude, waveform, dwell} tones.
// Optional SEQ_READBACK_EN adds a combinational table read port cfg_rdata_o.
module wave_sequencer #(
  parameter  int ENTRIES = 4,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we_i,
  input  logic [IDX_W-1:0] cfg_entry_i,
  input  logic [1:0]       cfg_field_i,
  input  logic [7:0]       cfg_data_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             loop_i,
  wave_sequencer_if.master gen,
  output logic             busy_o,
  output logic [IDX_W-1:0] entry_o,
  output logic             done_o
`ifdef SEQ_READBACK_EN
  ,
  output logic [7:0]       cfg_rdata_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_PH,
    S_LOAD_AMP,
    S_RUN,
    S_NEXT
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

  logic [7:0] phase_q [ENTRIES];
  logic [7:0] amp_q   [ENTRIES];
  logic [1:0] wave_q  [ENTRIES];
  logic [7:0] dwell_q [ENTRIES];

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       count_q, count_d;
  logic             done_q, done_d;

  // Table writes are only accepted while idle so a running sequence sees a stable table.
  // NOTE: the table is small and must return to known tones on reset, so it is built from
  // resettable flops rather than a RAM macro; a RAM cannot be cleared in a single cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        phase_q[i] <= 8'h00;
        amp_q[i]   <= 8'h7F;
        wave_q[i]  <= 2'd0;
        dwell_q[i] <= 8'h00;
      end
    end else if (cfg_we_i && (state_q == S_IDLE)) begin
      unique case (cfg_field_i)
        2'd0: phase_q[cfg_entry_i] <= cfg_data_i;
        2'd1: amp_q[cfg_entry_i]   <= cfg_data_i;
        2'd2: wave_q[cfg_entry_i]  <= cfg_data_i[1:0];
        2'd3: dwell_q[cfg_entry_i] <= cfg_data_i;
      endcase
    end
  end

  // NOTE: all state registers use non-blocking assignment so every flop samples the
  // pre-edge values computed by the combinational block below.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      count_q <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    done_d  = 1'b0;

    if (stop_i) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_d = S_LOAD_PH;
            idx_d   = '0;
          end
        end
        S_LOAD_PH: state_d = S_LOAD_AMP;
        S_LOAD_AMP: begin
          count_d = 8'h00;
          state_d = (dwell_q[idx_q] != 8'h00) ? S_RUN : S_NEXT;
        end
        S_RUN: begin
          if (gen.gen_valid) begin
            count_d = count_q + 8'd1;
            if (count_q == dwell_q[idx_q] - 8'd1) state_d = S_NEXT;
          end
        end
        S_NEXT: begin
          if (idx_q != LAST_IDX) begin
            state_d = S_LOAD_PH;
            idx_d   = idx_q + 1'b1;
          end else if (loop_i) begin
            state_d = S_LOAD_PH;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Moore output decode from registered state and index only.
  always_comb begin
    gen.gen_enable        = 1'b0;
    gen.gen_waveform      = 2'd0;
    gen.gen_set_phase     = 1'b0;
    gen.gen_set_amplitude = 1'b0;
    gen.gen_data          = 8'h00;

    unique case (state_q)
      S_LOAD_PH: begin
        gen.gen_set_phase = 1'b1;
        gen.gen_data      = phase_q[idx_q];
        gen.gen_waveform  = wave_q[idx_q];
      end
      S_LOAD_AMP: begin
        gen.gen_set_amplitude = 1'b1;
        gen.gen_data          = amp_q[idx_q];
        gen.gen_waveform      = wave_q[idx_q];
      end
      S_RUN: begin
        gen.gen_enable   = 1'b1;
        gen.gen_waveform = wave_q[idx_q];
      end
      S_NEXT:  gen.gen_waveform = wave_q[idx_q];
      default: ;
    endcase
  end

  assign busy_o  = (state_q != S_IDLE);
  assign entry_o = idx_q;
  assign done_o  = done_q;

`ifdef SEQ_READBACK_EN
  always_comb begin
    unique case (cfg_field_i)
      2'd0:    cfg_rdata_o = phase_q[cfg_entry_i];
      2'd1:    cfg_rdata_o = amp_q[cfg_entry_i];
      2'd2:    cfg_rdata_o = {6'b0, wave_q[cfg_entry_i]};
      default: cfg_rdata_o = dwell_q[cfg_entry_i];
    endcase
  end
`endif

endmodule

// File: tb/tb_wave_sequencer.sv
// Directed bench for wave_sequencer: per-cycle vector table for a single-tone run,
// plus hand-written sequences for loop, stop, write-while-busy and mid-run reset.
module tb_wave_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_we_i;
  logic [1:0] cfg_entry_i;
  logic [1:0] cfg_field_i;
  logic [7:0] cfg_data_i;
  logic       start_i, stop_i, loop_i;
  logic       busy_o, done_o;
  logic [1:0] entry_o;
`ifdef SEQ_READBACK_EN
  logic [7:0] cfg_rdata_o;
`endif

  int checks   = 0;
  int failures = 0;

  wave_sequencer_if gi ();

  wave_sequencer #(.ENTRIES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_we_i    (cfg_we_i),
    .cfg_entry_i (cfg_entry_i),
    .cfg_field_i (cfg_field_i),
    .cfg_data_i  (cfg_data_i),
    .start_i     (start_i),
    .stop_i      (stop_i),
    .loop_i      (loop_i),
    .gen         (gi.master),
    .busy_o      (busy_o),
    .entry_o     (entry_o),
    .done_o      (done_o)
`ifdef SEQ_READBACK_EN
    ,
    .cfg_rdata_o (cfg_rdata_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic       set_ph;
    logic       set_amp;
    logic       en;
    logic [7:0] data;
    logic [1:0] wave;
    logic [1:0] entry;
    logic       done;
  } obs_t;

  typedef struct {
    logic       we;
    logic [1:0] ent;
    logic [1:0] fld;
    logic [7:0] dat;
    logic       start;
    logic       stop;
    logic       valid;
    obs_t       exp;
  } vec_t;

  function automatic obs_t o(logic b, logic sp, logic sa, logic en, logic [7:0] d,
                             logic [1:0] w, logic [1:0] e, logic dn);
    o = '{busy: b, set_ph: sp, set_amp: sa, en: en, data: d, wave: w, entry: e, done: dn};
  endfunction

  function automatic vec_t v(logic we, logic [1:0] ent, logic [1:0] fld, logic [7:0] dat,
                             logic st, logic sp, logic vl, obs_t e);
    v = '{we: we, ent: ent, fld: fld, dat: dat, start: st, stop: sp, valid: vl, exp: e};
  endfunction

  function automatic obs_t sample();
    sample = '{busy: busy_o, set_ph: gi.gen_set_phase, set_amp: gi.gen_set_amplitude,
               en: gi.gen_enable, data: gi.gen_data, wave: gi.gen_waveform,
               entry: entry_o, done: done_o};
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs a full sequence with loop off and valid held low; reports busy/enable/done/entries.
  task automatic run_default(string tag);
    int busy_n = 0, en_n = 0, done_n = 0, ph_n = 0;
    logic [7:0] seq = 8'h00;
    start_i = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick();
      start_i = 1'b0;
      if (busy_o) busy_n++;
      if (gi.gen_enable) en_n++;
      if (done_o) done_n++;
      if (gi.gen_set_phase) begin
        ph_n++;
        seq = {seq[5:0], entry_o};
      end
    end
    check({tag, "_busy_cycles"}, busy_n, 12);
    check({tag, "_enable_cycles"}, en_n, 0);
    check({tag, "_done_pulses"}, done_n, 1);
    check({tag, "_phase_loads"}, ph_n, 4);
    check({tag, "_entry_order"}, seq, 8'h1B);
  endtask

  vec_t vecs[30];

  initial begin
    int found, dones, en_n;
    obs_t idle3, run0;

    rst_n = 1'b0; cfg_we_i = 1'b0; cfg_entry_i = '0; cfg_field_i = '0; cfg_data_i = '0;
    start_i = 1'b0; stop_i = 1'b0; loop_i = 1'b0; gi.gen_valid = 1'b0;

    idle3 = o(0, 0, 0, 0, 8'h00, 2'd0, 2'd3, 0);
    run0  = o(1, 0, 0, 1, 8'h00, 2'd2, 2'd0, 0);
    vecs[0]  = v(1, 2'd0, 2'd0, 8'h40, 0, 0, 0, idle3);
    vecs[1]  = v(1, 2'd0, 2'd1, 8'h20, 0, 0, 0, idle3);
    vecs[2]  = v(1, 2'd0, 2'd2, 8'h02, 0, 0, 0, idle3);
    vecs[3]  = v(1, 2'd0, 2'd3, 8'h03, 0, 0, 0, idle3);
    vecs[4]  = v(0, 2'd0, 2'd0, 8'h00, 1, 0, 0, o(1, 1, 0, 0, 8'h40, 2'd2, 2'd0, 0));
    vecs[5]  = v(0, 2'd0, 2'd0, 8'h00, 0, 0, 0, o(1, 0, 1, 0, 8'h20, 2'd2, 2'd0, 0));
    vecs[6]  = v(0, 2'd0, 2'd0, 8'h00, 0, 0, 0, run0);
    vecs[7]  = v(1, 2'd1, 2'd3, 8'h05, 0, 0, 0, run0);
    vecs[8]  = v(0, 2'd0, 2'd0, 8'h00, 0, 0, 0, run0);
    vecs[9]  = v(0, 2'd0, 2'd0, 8'h00, 0, 0, 1, run0);
    vecs[10] = v(0, 2'd0, 2'd0, 8'h00, 0, 0, 0, run0);
    vecs[11] = v(0, 2'd0, 2'd0, 8'h00, 0, 0, 0, run0);
    vecs[12] = v(0, 2'd0, 2'd0, 8'h00, 0, 0, 0, run0);
    vecs[13] = v(0, 2'd0, 2'd0, 8'h00, 0, 0, 1, run0);
    vecs[14] = v(0, 2'd0, 2'd0, 8'h00, 0, 0, 0, run0);
    vecs[15] = v(0, 2'd0, 2'd0, 8'h00, 0, 0, 0, run0);
    vecs[16] = v(0, 2'd0, 2'd0, 8'h00, 0, 0, 0, run0);
    vecs[17] = v(0, 2'd0, 2'd0, 8'h00, 0, 0, 1, o(1, 0, 0, 0, 8'h00, 2'd2, 2'd0, 0));
    for (int e = 1; e < 4; e++) begin
      vecs[15 + 3*e] = v(0, 2'd0, 2'd0, 8'h00, 0, 0, 0, o(1, 1, 0, 0, 8'h00, 2'd0, 2'(e), 0));
      vecs[16 + 3*e] = v(0, 2'd0, 2'd0, 8'h00, 0, 0, 0, o(1, 0, 1, 0, 8'h7F, 2'd0, 2'(e), 0));
      vecs[17 + 3*e] = v(0, 2'd0, 2'd0, 8'h00, 0, 0, 0, o(1, 0, 0, 0, 8'h00, 2'd0, 2'(e), 0));
    end
    vecs[27] = v(0, 2'd0, 2'd0, 8'h00, 0, 0, 0, o(0, 0, 0, 0, 8'h00, 2'd0, 2'd3, 1));
    vecs[28] = v(0, 2'd0, 2'd0, 8'h00, 1, 1, 0, idle3);
    vecs[29] = v(0, 2'd0, 2'd0, 8'h00, 0, 0, 0, idle3);

    // Reset state.
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("reset_outputs", sample(), o(0, 0, 0, 0, 8'h00, 2'd0, 2'd0, 0));

    // Default table: every entry has dwell 0, so each is skipped.
    run_default("default");

    // Single-tone run, write-while-busy, start+stop in idle.
    for (int i = 0; i < 30; i++) begin
      cfg_we_i = vecs[i].we; cfg_entry_i = vecs[i].ent; cfg_field_i = vecs[i].fld;
      cfg_data_i = vecs[i].dat; start_i = vecs[i].start; stop_i = vecs[i].stop;
      gi.gen_valid = vecs[i].valid;
      tick();
      check($sformatf("vec%0d", i), sample(), vecs[i].exp);
    end
    cfg_we_i = 1'b0; start_i = 1'b0; stop_i = 1'b0; gi.gen_valid = 1'b0;

`ifdef SEQ_READBACK_EN
    cfg_entry_i = 2'd1; cfg_field_i = 2'd3; #1;
    check("rdback_dwell1_ignored", cfg_rdata_o, 8'h00);
    cfg_entry_i = 2'd0; cfg_field_i = 2'd2; #1;
    check("rdback_wave0", cfg_rdata_o, 8'h02);
`endif

    // Looping: second pass reloads entry 0 at cycle 16, no done; then stop mid-RUN.
    loop_i = 1'b1; gi.gen_valid = 1'b1; found = 0; dones = 0;
    start_i = 1'b1;
    for (int c = 1; c <= 40 && found == 0; c++) begin
      tick();
      start_i = 1'b0;
      if (done_o) dones++;
      if (c > 1 && gi.gen_set_phase && entry_o == 2'd0) found = c;
    end
    check("loop_reload_cycle", found, 16);
    check("loop_reload_data", gi.gen_data, 8'h40);
    check("loop_no_done", dones, 0);
    tick(); tick();
    check("loop_in_run", gi.gen_enable, 1'b1);
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0; loop_i = 1'b0;
    check("stop_outputs", sample(), o(0, 0, 0, 0, 8'h00, 2'd0, 2'd0, 0));
    dones = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (done_o) dones++;
    end
    check("stop_no_done", dones, 0);

    // Write dwell[1]=5 while idle: accepted, so the run emits 3 + 5 enabled samples.
    cfg_we_i = 1'b1; cfg_entry_i = 2'd1; cfg_field_i = 2'd3; cfg_data_i = 8'h05;
    tick();
    cfg_we_i = 1'b0;
`ifdef SEQ_READBACK_EN
    check("rdback_dwell1_written", cfg_rdata_o, 8'h05);
`endif
    en_n = 0; dones = 0;
    start_i = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      start_i = 1'b0;
      if (gi.gen_enable) en_n++;
      if (done_o) dones++;
    end
    check("dwell_accepted_samples", en_n, 8);
    check("dwell_accepted_done", dones, 1);

    // Reset mid-RUN clears outputs and the table.
    gi.gen_valid = 1'b0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick(); tick();
    check("pre_reset_run", gi.gen_enable, 1'b1);
    rst_n = 1'b0;
    tick();
    check("midrun_reset_outputs", sample(), o(0, 0, 0, 0, 8'h00, 2'd0, 2'd0, 0));
    rst_n = 1'b1;
`ifdef SEQ_READBACK_EN
    cfg_entry_i = 2'd0; cfg_field_i = 2'd1; #1;
    check("rdback_amp_reset", cfg_rdata_o, 8'h7F);
`endif
    run_default("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
